// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and GF(2^8) helpers.
// The S-box is computed as inverse-then-affine rather than stored as a table.
package aes_pkg;

  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned AES_NR    = 10;

  typedef logic [31:0]          aes_word_t;
  typedef logic [AES_KEY_W-1:0] aes_rkey_t;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } ks_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (maps 0 to 0), followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] cnt);
    logic [7:0] r;
    case (cnt)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_schedule_expansion.sv
// One AES-128 key-expansion round: four current words in, four next words out.
module AES_KET_EXPANSION
  import aes_pkg::*;
(
  input  aes_word_t  w0_i,
  input  aes_word_t  w1_i,
  input  aes_word_t  w2_i,
  input  aes_word_t  w3_i,
  input  logic [3:0] cnt_i,
  output aes_word_t  w0_o,
  output aes_word_t  w1_o,
  output aes_word_t  w2_o,
  output aes_word_t  w3_o
);

  aes_word_t rot;
  aes_word_t sub;
  aes_word_t temp;

  always_comb begin
    rot  = {w3_i[23:0], w3_i[31:24]};
    sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    temp = sub ^ {rcon(cnt_i), 24'h000000};
    w0_o = w0_i ^ temp;
    w1_o = w1_i ^ w0_o;
    w2_o = w2_i ^ w1_o;
    w3_o = w3_i ^ w2_o;
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one expansion round per clock, all 11 round keys
// held in a resettable flop array behind a registered read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned KEY_W = AES_KEY_W,
  parameter int unsigned NR    = AES_NR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out
);

  ks_state_t        state_q, state_d;
  logic [3:0]       round_q, round_d;
  aes_word_t        w_q [4];
  aes_word_t        w_d [4];
  aes_word_t        wn  [4];
  logic [KEY_W-1:0] rk_q [NR+1];
  logic [KEY_W-1:0] rk_d [NR+1];
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  logic             accept;

  AES_KET_EXPANSION u_expand (
    .w0_i  (w_q[0]),
    .w1_i  (w_q[1]),
    .w2_i  (w_q[2]),
    .w3_i  (w_q[3]),
    .cnt_i (round_q),
    .w0_o  (wn[0]),
    .w1_o  (wn[1]),
    .w2_o  (wn[2]),
    .w3_o  (wn[3])
  );

  assign accept = key_valid && key_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (key_valid) state_d = StExpand;
      StExpand:       if (round_q == 4'(NR)) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    key_ready = (state_q == StIdle) || (state_q == StDone);
    busy      = (state_q == StExpand);
    done      = (state_q == StDone);
  end

  always_comb begin
    round_d = round_q;
    w_d     = w_q;
    rk_d    = rk_q;
    if (accept) begin
      rk_d[0] = key_in;
      w_d[0]  = key_in[127:96];
      w_d[1]  = key_in[95:64];
      w_d[2]  = key_in[63:32];
      w_d[3]  = key_in[31:0];
      round_d = 4'd1;
    end else if (busy) begin
      rk_d[round_q] = {wn[0], wn[1], wn[2], wn[3]};
      w_d           = wn;
      // The last round parks the counter at NR instead of wrapping past it.
      if (round_q != 4'(NR)) round_d = round_q + 4'd1;
    end
  end

  always_comb begin
    rk_out_d = '0;
    for (int i = 0; i <= int'(NR); i++) begin
      if (rk_idx == 4'(i)) rk_out_d = rk_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q  <= '0;
      rk_out_q <= '0;
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
      for (int i = 0; i <= int'(NR); i++) rk_q[i] <= '0;
    end else begin
      round_q  <= round_d;
      rk_out_q <= rk_out_d;
      w_q      <= w_d;
      rk_q     <= rk_d;
    end
  end

  assign rk_out = rk_out_q;

endmodule
